data_memory: RTL and testbench

DATA_MEMORY -- requirements
Module: data_memory

---
 rtl/data_memory_pkg.sv | 18 +
 rtl/data_memory.sv | 71 +++++++
 tb/tb_data_memory.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// ============================================================================
// Module   : data_memory_pkg
// Brief    : Default geometry and word type shared by data_memory users.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_memory_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_DEPTH  = 4096;

    typedef logic [DEFAULT_DATA_W-1:0] word_t;

endpackage : data_memory_pkg

`default_nettype wire

// File: rtl/data_memory.sv
// ============================================================================
// Module   : data_memory
// Brief    : Word-addressed DEPTH x DATA_W memory with a registered read port,
//            clearable by a synchronous active-low reset. DATA_MEMORY_BYPASS_EN
//            turns same-address read/write into write-first forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_memory
    import data_memory_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DEPTH  = DEFAULT_DEPTH
) (
    input  logic              read_enable,
    input  logic              write_enable,
    output logic [DATA_W-1:0] read_data,
    input  logic [DATA_W-1:0] write_data,
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] read_addr,
    input  logic [ADDR_W-1:0] write_addr
);

    localparam int              c_IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] c_DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_read_data;

    logic               w_rd_in_range;
    logic               w_wr_in_range;
    logic [c_IDX_W-1:0] w_rd_idx;
    logic [c_IDX_W-1:0] w_wr_idx;

    // Range check on a one-bit-wider address so DEPTH == 2**ADDR_W still works.
    assign w_rd_in_range = ({1'b0, read_addr}  < c_DEPTH_EXT);
    assign w_wr_in_range = ({1'b0, write_addr} < c_DEPTH_EXT);
    assign w_rd_idx      = read_addr[c_IDX_W-1:0];
    assign w_wr_idx      = write_addr[c_IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_read_data <= '0;
            r_mem       <= '{default: '0};
        end else begin
            if (write_enable && w_wr_in_range) begin
                r_mem[w_wr_idx] <= write_data;
            end
            if (read_enable) begin
                if (!w_rd_in_range) begin
                    r_read_data <= '0;
`ifdef DATA_MEMORY_BYPASS_EN
                end else if (write_enable && (read_addr == write_addr)) begin
                    r_read_data <= write_data;
`endif
                end else begin
                    // Non-blocking read of the pre-write word gives read-before-write.
                    r_read_data <= r_mem[w_rd_idx];
                end
            end
        end
    end

    assign read_data = r_read_data;

endmodule : data_memory

`default_nettype wire

// File: tb/tb_data_memory.sv
// ============================================================================
// Module   : tb_data_memory
// Brief    : Directed vector table plus randomized traffic for data_memory,
//            compared against an array-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_memory;
    import data_memory_pkg::*;

    localparam int c_DEPTH = DEFAULT_DEPTH;
    localparam int c_NVEC  = 22;
    localparam int c_NRAND = 400;

`ifdef DATA_MEMORY_BYPASS_EN
    localparam word_t c_SAME_ADDR_EXP = 16'hBEEF;
`else
    localparam word_t c_SAME_ADDR_EXP = 16'h1234;
`endif

    logic        clk;
    logic        reset;
    logic        read_enable;
    logic        write_enable;
    word_t       read_data;
    word_t       write_data;
    logic [15:0] read_addr;
    logic [15:0] write_addr;

    int passed;
    int total;

    word_t model_mem [c_DEPTH];
    word_t model_rd;

    typedef struct {
        logic  rst_n;
        logic  re;
        logic  we;
        logic [15:0] ra;
        logic [15:0] wa;
        word_t wd;
        word_t exp;
    } vec_t;

    vec_t vecs [c_NVEC];

    data_memory #(
        .DATA_W (DEFAULT_DATA_W),
        .ADDR_W (DEFAULT_ADDR_W),
        .DEPTH  (DEFAULT_DEPTH)
    ) dut (
        .read_enable  (read_enable),
        .write_enable (write_enable),
        .read_data    (read_data),
        .write_data   (write_data),
        .clk          (clk),
        .reset        (reset),
        .read_addr    (read_addr),
        .write_addr   (write_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference behaviour: the read sees the memory as it was before this edge.
    task automatic model_step(input logic rst_n, input logic re, input logic we,
                              input logic [15:0] ra, input logic [15:0] wa, input word_t wd);
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) model_mem[i] = '0;
            model_rd = '0;
        end else begin
            if (re) begin
                if (int'(ra) >= c_DEPTH) model_rd = '0;
`ifdef DATA_MEMORY_BYPASS_EN
                else if (we && ra == wa) model_rd = wd;
`endif
                else model_rd = model_mem[ra];
            end
            if (we && int'(wa) < c_DEPTH) model_mem[wa] = wd;
        end
    endtask

    task automatic cycle(input logic rst_n, input logic re, input logic we,
                         input logic [15:0] ra, input logic [15:0] wa, input word_t wd);
        @(negedge clk);
        reset        = rst_n;
        read_enable  = re;
        write_enable = we;
        read_addr    = ra;
        write_addr   = wa;
        write_data   = wd;
        @(posedge clk);
        model_step(rst_n, re, we, ra, wa, wd);
        #1;
    endtask

    task automatic check(input string name, input word_t exp);
        total++;
        if (read_data !== exp)
            $display("FAIL %s: read_data=%h expected=%h at %0t", name, read_data, exp, $time);
        else
            passed++;
    endtask

    initial begin
        passed       = 0;
        total        = 0;
        reset        = 1'b0;
        read_enable  = 1'b0;
        write_enable = 1'b0;
        read_addr    = '0;
        write_addr   = '0;
        write_data   = '0;
        model_rd     = '0;

        //           rst   re    we    ra        wa        wd        exp
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 16'h0003, 16'h0003, 16'h00AA, 16'h0000};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0000, 16'h0000};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0002, 16'h0001, 16'h0000};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h0002, 16'h0000, 16'h0000, 16'h0001};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'h0002, 16'h0005, 16'h7777, 16'h0001};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000, 16'h0000, 16'h0001};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0010, 16'h1234, 16'h0001};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 16'h0010, 16'h0010, 16'hBEEF, c_SAME_ADDR_EXP};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000, 16'hBEEF};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h5A5A, 16'hBEEF};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h1000, 16'hFFFF, 16'hBEEF};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 16'h1000, 16'h0000, 16'h0000, 16'h0000};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h5A5A};
        vecs[14] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0FFF, 16'hA5A5, 16'h5A5A};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 16'h0FFF, 16'h0000, 16'h0000, 16'hA5A5};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h5A5A};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0000, 16'h0000};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h1111, 16'h0000};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h0000, 16'h7777};
        vecs[20] = '{1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h0000, 16'h0000};
        vecs[21] = '{1'b1, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h0000, 16'h0000};

        for (int v = 0; v < c_NVEC; v++) begin
            cycle(vecs[v].rst_n, vecs[v].re, vecs[v].we, vecs[v].ra, vecs[v].wa, vecs[v].wd);
            check($sformatf("vec%0d", v), vecs[v].exp);
        end

        // Hold behaviour over several idle cycles after a fresh write and read.
        cycle(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0020, 16'hC0DE);
        cycle(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0000);
        check("seq_read_c0de", 16'hC0DE);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 1'b1, 16'h0020, 16'h0020, 16'h0BAD);
            check($sformatf("seq_hold%0d", k), 16'hC0DE);
        end
        cycle(1'b1, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0000);
        check("seq_read_0bad", 16'h0BAD);

        // Random traffic concentrated on a few low and boundary addresses.
        for (int n = 0; n < c_NRAND; n++) begin
            logic        rr;
            logic        re;
            logic        we;
            logic [15:0] ra;
            logic [15:0] wa;
            word_t       wd;
            rr = ($urandom_range(0, 49) != 0);
            re = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            ra = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'h0FFC, 16'h1003))
                                             : 16'($urandom_range(0, 7));
            wa = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'h0FFC, 16'h1003))
                                             : 16'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) wa = ra;
            wd = 16'($urandom);
            cycle(rr, re, we, ra, wa, wd);
            check($sformatf("rand%0d", n), model_rd);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_data_memory

`default_nettype wire
